// File: rtl/bist_response_analyzer.sv
// BIST response analyzer: MISR compaction of CUT responses, cycle counting and a sticky pass/fail verdict.
// Optional build macro BIST_XMASK_EN adds the xmask port so that masked response bits are excluded from compaction.
module bist_response_analyzer #(
    parameter int               WIDTH  = 16,
    parameter logic [WIDTH-1:0] POLY   = 16'h100B,
    parameter logic [WIDTH-1:0] SEED   = 16'h0000,
    parameter logic [WIDTH-1:0] GOLDEN = 16'h0000,
    parameter int               NCLOCK = 650,
    parameter int               CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             running,
    input  logic             finish,
    input  logic [WIDTH-1:0] resp_in,
`ifdef BIST_XMASK_EN
    input  logic [WIDTH-1:0] xmask,
`endif
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] comp_count,
    output logic             done,
    output logic             pass,
    output logic             fail
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_COMPACT = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [31:0] NCLK_W = 32'(NCLOCK);

    state_t           state, state_nxt;
    logic             step_en, cmp_en, match;
    logic [WIDTH-1:0] resp_eff;

    function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] sig,
                                                   input logic [WIDTH-1:0] data);
        logic [WIDTH-1:0] fb_taps;
        fb_taps = sig[WIDTH-1] ? POLY : '0;
        return {sig[WIDTH-2:0], 1'b0} ^ fb_taps ^ data;
    endfunction

    // Saturating increment: the count sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

`ifdef BIST_XMASK_EN
    assign resp_eff = resp_in & ~xmask;
`else
    assign resp_eff = resp_in;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (init) begin
            state_nxt = S_ARMED;
        end else begin
            unique case (state)
                S_IDLE:    state_nxt = S_IDLE;
                S_ARMED: begin
                    if (finish)       state_nxt = S_COMPARE;
                    else if (running) state_nxt = S_COMPACT;
                end
                S_COMPACT: if (finish) state_nxt = S_COMPARE;
                S_COMPARE: state_nxt = S_DONE;
                S_DONE:    state_nxt = S_DONE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // init overrides everything else on the same edge, so both enables are gated by it.
    always_comb begin
        step_en = 1'b0;
        cmp_en  = 1'b0;
        if (!init) begin
            step_en = running && ((state == S_ARMED) || (state == S_COMPACT));
            cmp_en  = (state == S_COMPARE);
        end
    end

    assign match = (signature == GOLDEN) && (32'(comp_count) == NCLK_W);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            signature  <= SEED;
            comp_count <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
        end else if (init) begin
            signature  <= SEED;
            comp_count <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
        end else begin
            if (step_en) begin
                signature  <= misr_step(signature, resp_eff);
                comp_count <= sat_inc(comp_count);
            end
            if (cmp_en) begin
                done <= 1'b1;
                pass <= match;
                fail <= !match;
            end
        end
    end

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Randomized bench for bist_response_analyzer: four parameterizations share one stimulus stream and are
// compared every cycle against a transaction-level model (signature as polynomial residue, saturating count).
module tb_bist_response_analyzer;

    localparam bit XM = `ifdef BIST_XMASK_EN 1'b1 `else 1'b0 `endif;
    localparam logic [16:0] FULL_POLY = {1'b1, 16'h100B};

    logic        clk = 1'b0;
    logic        reset, init, running, finish;
    logic [15:0] resp_in;
`ifdef BIST_XMASK_EN
    logic [15:0] xmask;
`endif
    logic [15:0] sig [4];
    logic [15:0] cnt0, cnt1, cnt2;
    logic [3:0]  cnt3;
    logic        dn [4];
    logic        ps [4];
    logic        fl [4];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Instance parameters: default / short golden run / feedback seed / 4-bit saturating counter.
    logic [15:0] m_seed [4] = '{16'h0000, 16'h0000, 16'h8000, 16'h0000};
    logic [15:0] m_gold [4] = '{16'h0000, 16'h0002, 16'h100B, 16'h0000};
    int          m_ncl  [4] = '{650, 2, 1, 15};
    int          m_cmax [4] = '{65535, 65535, 65535, 15};

    bist_response_analyzer u0 (.clk(clk), .reset(reset), .init(init), .running(running), .finish(finish),
        .resp_in(resp_in),
`ifdef BIST_XMASK_EN
        .xmask(xmask),
`endif
        .signature(sig[0]), .comp_count(cnt0), .done(dn[0]), .pass(ps[0]), .fail(fl[0]));

    bist_response_analyzer #(.NCLOCK(2), .GOLDEN(16'h0002)) u1 (.clk(clk), .reset(reset), .init(init),
        .running(running), .finish(finish), .resp_in(resp_in),
`ifdef BIST_XMASK_EN
        .xmask(xmask),
`endif
        .signature(sig[1]), .comp_count(cnt1), .done(dn[1]), .pass(ps[1]), .fail(fl[1]));

    bist_response_analyzer #(.SEED(16'h8000), .GOLDEN(16'h100B), .NCLOCK(1)) u2 (.clk(clk), .reset(reset),
        .init(init), .running(running), .finish(finish), .resp_in(resp_in),
`ifdef BIST_XMASK_EN
        .xmask(xmask),
`endif
        .signature(sig[2]), .comp_count(cnt2), .done(dn[2]), .pass(ps[2]), .fail(fl[2]));

    bist_response_analyzer #(.CNT_W(4), .NCLOCK(15)) u3 (.clk(clk), .reset(reset), .init(init),
        .running(running), .finish(finish), .resp_in(resp_in),
`ifdef BIST_XMASK_EN
        .xmask(xmask),
`endif
        .signature(sig[3]), .comp_count(cnt3), .done(dn[3]), .pass(ps[3]), .fail(fl[3]));

    // Reference model: phase 0 idle, 1 armed, 2 compacting, 3 comparing, 4 verdict held.
    int          phase;
    logic [15:0] msig  [4];
    int          mcnt  [4];
    bit          mdone;
    bit          mpass [4];

    function automatic logic [31:0] get_cnt(input int k);
        case (k)
            0:       return {16'h0, cnt0};
            1:       return {16'h0, cnt1};
            2:       return {16'h0, cnt2};
            default: return {28'h0, cnt3};
        endcase
    endfunction

    // Signature is the residue of (previous * x + word) modulo x^16 + POLY.
    function automatic logic [15:0] residue_shift_add(input logic [15:0] s, input logic [15:0] w);
        logic [16:0] v;
        v = {s, 1'b0} ^ {1'b0, w};
        if (v[16]) v = v ^ FULL_POLY;
        return v[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s u%0d signature", where, k), {16'h0, sig[k]}, {16'h0, msig[k]});
            chk($sformatf("%s u%0d comp_count", where, k), get_cnt(k), 32'(mcnt[k]));
            chk($sformatf("%s u%0d done", where, k), 32'(dn[k]), 32'(mdone));
            chk($sformatf("%s u%0d pass", where, k), 32'(ps[k]), 32'(mdone && mpass[k]));
            chk($sformatf("%s u%0d fail", where, k), 32'(fl[k]), 32'(mdone && !mpass[k]));
        end
    endtask

    task automatic model_clear(input int ph);
        phase = ph;
        mdone = 1'b0;
        for (int k = 0; k < 4; k++) begin
            msig[k]  = m_seed[k];
            mcnt[k]  = 0;
            mpass[k] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit i, input bit r, input bit f, input logic [15:0] w);
        if (i) begin
            model_clear(1);
        end else if (phase == 1 || phase == 2) begin
            if (r) begin
                for (int k = 0; k < 4; k++) begin
                    msig[k] = residue_shift_add(msig[k], w);
                    mcnt[k] = (mcnt[k] < m_cmax[k]) ? mcnt[k] + 1 : m_cmax[k];
                end
            end
            if (f)      phase = 3;
            else if (r) phase = 2;
        end else if (phase == 3) begin
            mdone = 1'b1;
            for (int k = 0; k < 4; k++)
                mpass[k] = (msig[k] == m_gold[k]) && (mcnt[k] == m_ncl[k]);
            phase = 4;
        end
    endtask

    task automatic cyc(input bit i, input bit r, input bit f, input logic [15:0] d, input logic [15:0] m);
        logic [15:0] eff;
        init    = i;
        running = r;
        finish  = f;
        resp_in = d;
`ifdef BIST_XMASK_EN
        xmask   = m;
`endif
        eff = d & ~(XM ? m : 16'h0000);
        @(posedge clk);
        model_edge(i, r, f, eff);
        #1;
        check_all("cyc");
    endtask

    task automatic run(input int n, input bit rnd, input bit gaps, input bit rnd_mask, input logic [15:0] m);
        for (int j = 0; j < n; j++) begin
            if (gaps && $urandom_range(0, 3) == 0)
                cyc(0, 0, 0, 16'($urandom), rnd_mask ? 16'($urandom) : m);
            cyc(0, 1, 0, rnd ? 16'($urandom) : 16'h0000, rnd_mask ? 16'($urandom) : m);
        end
    endtask

    task automatic fin();
        cyc(0, 0, 1, 16'h0, 16'h0);
        cyc(0, 0, 0, 16'h0, 16'h0);
        cyc(0, 1, 1, 16'($urandom), 16'h0);
    endtask

    task automatic hit_reset();
        reset = 1'b1;
        #1;
        model_clear(0);
        check_all("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("reset held");
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; running = 1'b0; finish = 1'b0; resp_in = '0;
`ifdef BIST_XMASK_EN
        xmask = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        model_clear(0);
        check_all("power-on");
        chk("por signature u2", {16'h0, sig[2]}, 32'h8000);
        reset = 1'b0;

        // Idle ignores running/finish until an init arrives.
        for (int j = 0; j < 3; j++) cyc(0, 1, 1, 16'($urandom), 16'h0);

        // Full-length all-zero run.
        cyc(1, 0, 0, 16'h0, 16'h0);
        run(650, 0, 0, 0, 16'h0);
        cyc(0, 0, 1, 16'h0, 16'h0);
        chk("t1 done before", 32'(dn[0]), 0);
        cyc(0, 0, 0, 16'h0, 16'h0);
        chk("t1 done after", 32'(dn[0]), 1);
        chk("t1 signature", {16'h0, sig[0]}, 32'h0000);
        chk("t1 comp_count", get_cnt(0), 650);
        chk("t1 pass", 32'(ps[0]), 1);
        chk("t1 fail", 32'(fl[0]), 0);
        chk("t1 sat count", get_cnt(3), 15);
        chk("t1 sat pass", 32'(ps[3]), 1);

        // Two-cycle golden run, then a corrupted repeat.
        cyc(1, 0, 0, 16'h0, 16'h0);
        cyc(0, 1, 0, 16'h0001, 16'h0);
        cyc(0, 1, 0, 16'h0000, 16'h0);
        fin();
        chk("t2 signature", {16'h0, sig[1]}, 32'h0002);
        chk("t2 pass", 32'(ps[1]), 1);
        cyc(1, 0, 0, 16'h0, 16'h0);
        cyc(0, 1, 0, 16'h0003, 16'h0);
        cyc(0, 1, 0, 16'h0000, 16'h0);
        fin();
        chk("t2b signature", {16'h0, sig[1]}, 32'h0006);
        chk("t2b fail", 32'(fl[1]), 1);

        // Feedback tap check from seed 8000.
        cyc(1, 0, 0, 16'h0, 16'h0);
        cyc(0, 1, 0, 16'h0000, 16'h0);
        chk("t3 signature", {16'h0, sig[2]}, 32'h100B);
        chk("t3 comp_count", get_cnt(2), 1);
        fin();
        chk("t3 pass", 32'(ps[2]), 1);

        // Zero-length run.
        cyc(1, 0, 0, 16'h0, 16'h0);
        fin();
        chk("zero-len comp_count", get_cnt(0), 0);
        chk("zero-len fail", 32'(fl[0]), 1);

        // Reset mid-run, then a clean full run.
        cyc(1, 0, 0, 16'h0, 16'h0);
        run(50, 1, 0, 0, 16'h0);
        hit_reset();
        chk("rst signature u2", {16'h0, sig[2]}, 32'h8000);
        chk("rst comp_count", get_cnt(0), 0);
        chk("rst done", 32'(dn[0]), 0);
        for (int j = 0; j < 3; j++) cyc(0, 1, 0, 16'($urandom), 16'h0);
        cyc(1, 0, 0, 16'h0, 16'h0);
        run(650, 0, 0, 0, 16'h0);
        fin();
        chk("rerun comp_count", get_cnt(0), 650);
        chk("rerun pass", 32'(ps[0]), 1);

        // init and finish on the same edge while compacting.
        cyc(1, 0, 0, 16'h0, 16'h0);
        run(20, 1, 1, 0, 16'h0);
        cyc(1, 1, 1, 16'($urandom), 16'h0);
        chk("init+finish comp_count", get_cnt(0), 0);
        chk("init+finish done", 32'(dn[0]), 0);
        cyc(0, 0, 0, 16'h0, 16'h0);
        chk("init+finish done later", 32'(dn[0]), 0);
        run(650, 0, 1, 0, 16'h0);
        fin();
        chk("second run pass", 32'(ps[0]), 1);

        // Fully masked random responses: only the masked build can match the all-zero golden.
        cyc(1, 0, 0, 16'h0, 16'h0);
        run(650, 1, 0, 0, 16'hFFFF);
        fin();
        chk("xmask pass", 32'(ps[0]), 32'(XM));

        // Random run with random gaps and masks.
        cyc(1, 0, 0, 16'h0, 16'h0);
        run(300, 1, 1, 1, 16'h0);
        fin();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
